// File: rtl/rr_arb8.sv
// rr_arb8 - eight-way round-robin arbiter with bounded grant hold time.
//
// Picks at most one of eight level-held requesters per cycle and presents the
// winner both as a one-hot grant and as a 3-bit index (the same encoding as the
// team's 8:3 encoder). An owner keeps the grant while it keeps requesting; once
// another requester is waiting, the owner is limited to MAX_HOLD consecutive
// cycles before the grant is rotated away from it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         arbitration enable; low blocks new grants only, it never ends
//              a grant that is already in progress
//   req[7:0]   request vector, bit i belongs to requester i
//   gnt[7:0]   registered one-hot grant, zero when idle
//   gnt_idx    registered binary index of the owner, zero when idle
//   gnt_valid  registered, high exactly when gnt is nonzero
//   hold_cnt   registered number of cycles the current grant has been held,
//              zero when idle

module rr_arb8 #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [7:0]       req,
  output logic [7:0]       gnt,
  output logic [2:0]       gnt_idx,
  output logic             gnt_valid,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       ptr;
  logic [2:0]       ptr_nxt;
  logic [2:0]       idx_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [7:0]       gnt_nxt;
  logic [7:0]       others;
  logic [2:0]       after_owner;
  logic [3:0]       win_idle;
  logic [3:0]       win_rot;

  // Returns {found, index} of the first set bit of r at or after start,
  // wrapping 7 -> 0. The 3-bit sum wraps naturally, giving the modulo-8 scan;
  // scanning the offsets from highest to lowest lets the nearest one win.
  function automatic logic [3:0] find_winner(input logic [7:0] r,
                                             input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] i;
    res = 4'b0;
    for (int o = 7; o >= 0; o--) begin
      i = start + 3'(o);
      if (r[i]) res = {1'b1, i};
    end
    return res;
  endfunction

  // Requests other than the current owner's; gnt is all zero when idle, so in
  // IDLE this is simply req.
  assign others      = req & ~gnt;
  assign after_owner = gnt_idx + 3'd1;
  assign win_idle    = find_winner(req, ptr);
  assign win_rot     = find_winner(others, after_owner);

  // The state register holds the only notion of ownership, so the valid flag
  // is a direct flop output.
  assign gnt_valid = (state == GRANT);

  // State, pointer and output registers. Everything visible is a flop so there
  // is no combinational path from req to the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      gnt      <= 8'd0;
      gnt_idx  <= 3'd0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gnt      <= gnt_nxt;
      gnt_idx  <= idx_nxt;
      hold_cnt <= cnt_nxt;
    end
  end

  // Next-state decision. In IDLE a new grant needs en. In GRANT the owner
  // either keeps going (counter saturating at MAX_HOLD while nobody else
  // waits), is forced off after MAX_HOLD cycles of contention, or releases.
  // Whenever ownership ends the pointer moves past the old owner, and a
  // successor is granted on the same edge only if en allows it.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = gnt_idx;
    cnt_nxt   = hold_cnt;

    unique case (state)
      IDLE: begin
        if (en && win_idle[3]) begin
          state_nxt = GRANT;
          idx_nxt   = win_idle[2:0];
          cnt_nxt   = HOLD_ONE;
        end
      end

      GRANT: begin
        if (req[gnt_idx] && (others == 8'd0 || hold_cnt < HOLD_MAX)) begin
          cnt_nxt = (hold_cnt >= HOLD_MAX) ? HOLD_MAX : hold_cnt + HOLD_ONE;
        end else begin
          ptr_nxt = after_owner;
          if (en && win_rot[3]) begin
            idx_nxt = win_rot[2:0];
            cnt_nxt = HOLD_ONE;
          end else begin
            state_nxt = IDLE;
            idx_nxt   = 3'd0;
            cnt_nxt   = '0;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        idx_nxt   = 3'd0;
        cnt_nxt   = '0;
      end
    endcase

    gnt_nxt = (state_nxt == GRANT) ? (8'd1 << idx_nxt) : 8'd0;
  end

endmodule

// File: tb/tb_rr_arb8.sv
// tb_rr_arb8 - self-checking bench for rr_arb8.
//
// A behavioural model (owner number, hold count, priority pointer) is stepped
// on every rising edge and all outputs are compared 1 ns later. Directed
// scenarios add hand-computed literal expectations, then a randomized phase
// exercises contention, enable and release patterns.

module tb_rr_arb8;

  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [7:0]       req = 8'd0;
  logic [7:0]       gnt;
  logic [2:0]       gnt_idx;
  logic             gnt_valid;
  logic [CNT_W-1:0] hold_cnt;

  int n_vectors     = 0;
  int n_miscompares = 0;

  // Model state: owner is -1 when idle.
  int m_owner = -1;
  int m_hold  = 0;
  int m_ptr   = 0;

  always #5 clk = ~clk;

  rr_arb8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .hold_cnt  (hold_cnt)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual,
               expected, $time);
    end
  endtask

  // First requester in r at or after start (mod 8), skipping excl; -1 if none.
  function automatic int search(input logic [7:0] r, input int start,
                                input int excl);
    for (int o = 0; o < 8; o++) begin
      int i;
      i = (start + o) % 8;
      if (i != excl && r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_ptr   = 0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic e);
    logic [7:0] rest;
    int         w;
    if (m_owner < 0) begin
      if (e && r != 8'd0) begin
        m_owner = search(r, m_ptr, -1);
        m_hold  = 1;
      end
    end else begin
      rest = r;
      rest[m_owner] = 1'b0;
      if (r[m_owner] && (rest == 8'd0 || m_hold < MAX_HOLD)) begin
        m_hold = (m_hold + 1 > MAX_HOLD) ? MAX_HOLD : m_hold + 1;
      end else begin
        m_ptr = (m_owner + 1) % 8;
        w = search(r, m_ptr, m_owner);
        if (e && w >= 0) begin
          m_owner = w;
          m_hold  = 1;
        end else begin
          m_owner = -1;
          m_hold  = 0;
        end
      end
    end
  endtask

  always @(negedge rst_n) model_reset();

  // Single compare process: step the model on each edge, check 1 ns later.
  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step(req, en);
    #1;
    check_output("gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check_output("gnt_idx", 32'(gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check_output("gnt_valid", 32'(gnt_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
    check_output("hold_cnt", 32'(hold_cnt), 32'(m_hold));
  end

  task automatic apply_stimulus(input logic [7:0] r, input logic e);
    req = r;
    en  = e;
  endtask

  // Advance n rising edges and settle 2 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    $display("[TB] rr_arb8 bench start");

    // Reset values while rst_n is low.
    #3;
    check_output("reset_gnt", 32'(gnt), 32'd0);
    check_output("reset_valid", 32'(gnt_valid), 32'd0);
    check_output("reset_hold", 32'(hold_cnt), 32'd0);
    tick(2);
    rst_n = 1'b1;

    // Single request: one-cycle latency, index 2.
    apply_stimulus(8'b0000_0100, 1'b1);
    tick(1);
    check_output("single_gnt", 32'(gnt), 32'h04);
    check_output("single_idx", 32'(gnt_idx), 32'd2);
    check_output("single_hold", 32'(hold_cnt), 32'd1);
    apply_stimulus(8'd0, 1'b1);
    tick(1);
    check_output("single_release", 32'(gnt_valid), 32'd0);

    // Sweep one requester at a time.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(8'd1 << i, 1'b1);
      tick(1);
      check_output("sweep_idx", 32'(gnt_idx), 32'(i));
      check_output("sweep_gnt", 32'(gnt), 32'd1 << i);
      tick(2);
      apply_stimulus(8'd0, 1'b1);
      tick(1);
    end

    // Full contention: each owner exactly MAX_HOLD cycles, 0..7 then 0.
    apply_stimulus(8'hFF, 1'b1);
    for (int j = 0; j < 33; j++) begin
      tick(1);
      check_output("fair_idx", 32'(gnt_idx), 32'((j / MAX_HOLD) % 8));
      check_output("fair_hold", 32'(hold_cnt), 32'((j % MAX_HOLD) + 1));
    end
    apply_stimulus(8'd0, 1'b1);
    tick(1);

    // Release and wrap: owner 6 drops, 7 wins over 1, then 1.
    apply_stimulus(8'h40, 1'b1);
    tick(1);
    check_output("wrap_owner6", 32'(gnt_idx), 32'd6);
    apply_stimulus(8'hC2, 1'b1);
    tick(1);
    apply_stimulus(8'h82, 1'b1);
    tick(1);
    check_output("wrap_to7", 32'(gnt), 32'h80);
    apply_stimulus(8'h02, 1'b1);
    tick(1);
    check_output("wrap_to1", 32'(gnt), 32'h02);
    apply_stimulus(8'd0, 1'b1);
    tick(1);

    // Solo saturation on requester 3.
    apply_stimulus(8'h08, 1'b1);
    tick(10);
    check_output("solo_idx", 32'(gnt_idx), 32'd3);
    check_output("solo_hold", 32'(hold_cnt), 32'd4);
    apply_stimulus(8'd0, 1'b1);
    tick(1);

    // Enable: blocked while low, grant in progress survives en=0.
    apply_stimulus(8'h10, 1'b0);
    tick(3);
    check_output("en_block", 32'(gnt), 32'd0);
    apply_stimulus(8'h10, 1'b1);
    tick(1);
    check_output("en_grant", 32'(gnt), 32'h10);
    apply_stimulus(8'h10, 1'b0);
    tick(3);
    check_output("en_keep", 32'(gnt), 32'h10);
    apply_stimulus(8'd0, 1'b0);
    tick(1);
    check_output("en_idle", 32'(gnt_valid), 32'd0);
    apply_stimulus(8'h10, 1'b0);
    tick(2);
    check_output("en_idle2", 32'(gnt), 32'd0);

    // Async reset mid-grant, then priority restarts at requester 0.
    apply_stimulus(8'h20, 1'b1);
    tick(2);
    check_output("pre_reset", 32'(gnt), 32'h20);
    rst_n = 1'b0;
    #1;
    check_output("async_gnt", 32'(gnt), 32'd0);
    check_output("async_valid", 32'(gnt_valid), 32'd0);
    tick(1);
    rst_n = 1'b1;
    apply_stimulus(8'h28, 1'b1);
    tick(1);
    check_output("post_reset_ptr0", 32'(gnt_idx), 32'd3);
    apply_stimulus(8'd0, 1'b1);
    tick(1);

    // Randomized phase against the model.
    for (int k = 0; k < 600; k++) begin
      logic [7:0] r;
      r = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 9) == 0) r = 8'hFF;
      apply_stimulus(r, ($urandom_range(0, 4) != 0));
      tick(1);
    end

    apply_stimulus(8'd0, 1'b1);
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors,
             n_miscompares);
    $finish;
  end

endmodule
